// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide unit and the control unit.
package muldiv_pkg;

    // funct3 encoding of the M-extension operations
    typedef enum logic [2:0] {
        MD_MUL    = 3'b000,
        MD_MULH   = 3'b001,
        MD_MULHSU = 3'b010,
        MD_MULHU  = 3'b011,
        MD_DIV    = 3'b100,
        MD_DIVU   = 3'b101,
        MD_REM    = 3'b110,
        MD_REMU   = 3'b111
    } md_op_e;

    // funct7 value that selects the M-extension in OP-class instructions
    localparam logic [6:0] MD_FUNCT7 = 7'b0000001;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10
    } md_state_e;

    // rs1 is interpreted as signed
    function automatic logic op_a_signed(input md_op_e op);
        return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
    endfunction

    // rs2 is interpreted as signed
    function automatic logic op_b_signed(input md_op_e op);
        return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
    endfunction

    // divide/remainder family (funct3[2] set)
    function automatic logic op_is_div(input md_op_e op);
        return op[2];
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between the Execute stage and the muldiv unit.
interface muldiv_if
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) ();
    logic            flush;
    logic            start;
    md_op_e          op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output flush, start, op, a, b,
        input  busy, done, result
    );

    modport slave (
        input  flush, start, op, a, b,
        output busy, done, result
    );
endinterface

// File: rtl/muldiv_step.sv
// One radix-2 iteration shared by multiply and divide.
//   multiply: acc = {partial product high, remaining multiplier}; add-if-lsb then shift right
//   divide:   acc = {partial remainder, remaining dividend / quotient bits}; restoring shift-subtract
module muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic [2*XLEN-1:0] acc_i,
    input  logic [XLEN-1:0]   operand_i,
    input  logic              mode_div_i,
    output logic [2*XLEN-1:0] acc_o
);
    logic [XLEN:0] sum;
    logic [XLEN:0] rem_sh;
    logic [XLEN:0] diff;
    logic          ge;

    // Single iteration; the carry of the add lands in the top bit after the right shift
    always_comb begin
        sum    = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, operand_i} : '0);
        rem_sh = acc_i[2*XLEN-1:XLEN-1];
        diff   = rem_sh - {1'b0, operand_i};
        ge     = (rem_sh >= {1'b0, operand_i});
        if (mode_div_i) begin
            acc_o = {(ge ? diff[XLEN-1:0] : rem_sh[XLEN-1:0]), acc_i[XLEN-2:0], ge};
        end else begin
            acc_o = {sum, acc_i[XLEN-1:1]};
        end
    end
endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: magnitudes are processed UNROLL bits per
// cycle and the sign/special-case correction is applied in a final FIX cycle.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int UNROLL    = 1,
    parameter int EARLY_OUT = 1
) (
    input  logic     clk,
    input  logic     reset,
    muldiv_if.slave  bus
);
    localparam int N  = XLEN / UNROLL;
    localparam int CW = $clog2(N + 1);

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_CALC = CALC;
    localparam logic [1:0] S_FIX  = FIX;

    logic [1:0]        state_q,  state_d;
    logic [CW-1:0]     cnt_q,    cnt_d;
    logic [2*XLEN-1:0] acc_q,    acc_d;
    logic [XLEN-1:0]   opnd_q,   opnd_d;
    logic [XLEN-1:0]   a_q,      a_d;
    logic [2:0]        op_q,     op_d;
    logic              neg_q,    neg_d;
    logic              rneg_q,   rneg_d;
    logic              divz_q,   divz_d;
    logic              ovf_q,    ovf_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              done_q,   done_d;
    logic              busy_q,   busy_d;

    logic              a_sgn, b_sgn, divz, ovf;
    logic [XLEN-1:0]   abs_a, abs_b;
    logic [2*XLEN-1:0] chain [0:UNROLL];

    // Sign-correct the magnitude result and select the architectural field
    function automatic logic [XLEN-1:0] fix_result(
        input logic [2:0]        op,
        input logic [2*XLEN-1:0] acc,
        input logic              neg,
        input logic              rneg,
        input logic              divz_f,
        input logic              ovf_f,
        input logic [XLEN-1:0]   a_orig
    );
        logic [2*XLEN-1:0] prod;
        logic [XLEN-1:0]   quo;
        logic [XLEN-1:0]   rem;
        prod = neg  ? -acc : acc;
        quo  = neg  ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem  = rneg ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        if (divz_f) begin
            quo = '1;
            rem = a_orig;
        end else if (ovf_f) begin
            quo = a_orig;
            rem = '0;
        end
        case (op)
            MD_MUL:                       return prod[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: return prod[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:              return quo;
            default:                      return rem;
        endcase
    endfunction

    assign chain[0] = acc_q;
    for (genvar g = 0; g < UNROLL; g++) begin : g_step
        muldiv_step #(.XLEN(XLEN)) u_step (
            .acc_i      (chain[g]),
            .operand_i  (opnd_q),
            .mode_div_i (op_q[2]),
            .acc_o      (chain[g+1])
        );
    end

    // Next-state: accept in IDLE, iterate in CALC, correct and publish in FIX; flush overrides
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        a_d      = a_q;
        op_d     = op_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        divz_d   = divz_q;
        ovf_d    = ovf_q;
        result_d = result_q;
        done_d   = 1'b0;

        a_sgn = op_a_signed(bus.op) && bus.a[XLEN-1];
        b_sgn = op_b_signed(bus.op) && bus.b[XLEN-1];
        abs_a = a_sgn ? -bus.a : bus.a;
        abs_b = b_sgn ? -bus.b : bus.b;
        divz  = op_is_div(bus.op) && (bus.b == '0);
        ovf   = op_is_div(bus.op) && op_a_signed(bus.op) &&
                (bus.a == {1'b1, {(XLEN-1){1'b0}}}) && (bus.b == '1);

        case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.flush) begin
                    op_d   = bus.op;
                    a_d    = bus.a;
                    neg_d  = a_sgn ^ b_sgn;
                    rneg_d = a_sgn;
                    divz_d = divz;
                    ovf_d  = ovf;
                    cnt_d  = '0;
                    if (op_is_div(bus.op)) begin
                        opnd_d = abs_b;
                        acc_d  = {{XLEN{1'b0}}, abs_a};
                    end else begin
                        opnd_d = abs_a;
                        acc_d  = {{XLEN{1'b0}}, abs_b};
                    end
                    state_d = ((EARLY_OUT != 0) && (divz || ovf)) ? S_FIX : S_CALC;
                end
            end
            S_CALC: begin
                acc_d = chain[UNROLL];
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(N - 1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                result_d = fix_result(op_q, acc_q, neg_q, rneg_q, divz_q, ovf_q, a_q);
                done_d   = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (bus.flush) begin
            state_d  = S_IDLE;
            done_d   = 1'b0;
            result_d = result_q;
        end

        busy_d = (state_d != S_IDLE);
    end

    // State and datapath registers, cleared by the synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            a_q      <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            divz_q   <= 1'b0;
            ovf_q    <= 1'b0;
            result_q <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            a_q      <= a_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            divz_q   <= divz_d;
            ovf_q    <= ovf_d;
            result_q <= result_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: three instances (UNROLL=1/EARLY_OUT=1, UNROLL=1/EARLY_OUT=0,
// UNROLL=4/EARLY_OUT=1) share operands; each has its own start line.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam logic [31:0] MIN32 = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  st;
    logic        flush;
    md_op_e      op;
    logic [31:0] a, b;

    always #5 clk = ~clk;

    muldiv_if #(.XLEN(32)) if0 ();
    muldiv_if #(.XLEN(32)) if1 ();
    muldiv_if #(.XLEN(32)) if2 ();

    assign if0.start = st[0];
    assign if1.start = st[1];
    assign if2.start = st[2];
    assign if0.flush = flush;
    assign if1.flush = flush;
    assign if2.flush = flush;
    assign if0.op = op;
    assign if1.op = op;
    assign if2.op = op;
    assign if0.a = a;
    assign if1.a = a;
    assign if2.a = a;
    assign if0.b = b;
    assign if1.b = b;
    assign if2.b = b;

    muldiv_unit #(.XLEN(32), .UNROLL(1), .EARLY_OUT(1)) dut0 (.clk(clk), .reset(reset), .bus(if0));
    muldiv_unit #(.XLEN(32), .UNROLL(1), .EARLY_OUT(0)) dut1 (.clk(clk), .reset(reset), .bus(if1));
    muldiv_unit #(.XLEN(32), .UNROLL(4), .EARLY_OUT(1)) dut2 (.clk(clk), .reset(reset), .bus(if2));

    logic        dn [3];
    logic        bz [3];
    logic [31:0] rs [3];
    assign dn[0] = if0.done;
    assign dn[1] = if1.done;
    assign dn[2] = if2.done;
    assign bz[0] = if0.busy;
    assign bz[1] = if1.busy;
    assign bz[2] = if2.busy;
    assign rs[0] = if0.result;
    assign rs[1] = if1.result;
    assign rs[2] = if2.result;

    int unroll_c [3] = '{1, 1, 4};
    int eo_c     [3] = '{1, 0, 1};

    int n_err = 0;
    int n_chk = 0;
    logic [31:0] last_exp;

    typedef struct {
        md_op_e      o;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] e;
    } vec_t;
    vec_t tbl [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Architectural reference computed with 64-bit integer arithmetic
    function automatic logic [31:0] model(input md_op_e o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, ux, uy;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = longint'({32'b0, x});
        uy = longint'({32'b0, y});
        case (o)
            MD_MUL:    begin p = ux * uy; return p[31:0];  end
            MD_MULH:   begin p = sx * sy; return p[63:32]; end
            MD_MULHSU: begin p = sx * uy; return p[63:32]; end
            MD_MULHU:  begin p = ux * uy; return p[63:32]; end
            MD_DIV: begin
                if (y == 0) return 32'hFFFF_FFFF;
                if (x == MIN32 && y == 32'hFFFF_FFFF) return x;
                return 32'(sx / sy);
            end
            MD_DIVU:   return (y == 0) ? 32'hFFFF_FFFF : x / y;
            MD_REM: begin
                if (y == 0) return x;
                if (x == MIN32 && y == 32'hFFFF_FFFF) return 32'h0;
                return 32'(sx % sy);
            end
            default:   return (y == 0) ? x : x % y;
        endcase
    endfunction

    function automatic int exp_lat(input int d, input md_op_e o, input logic [31:0] x, input logic [31:0] y);
        logic special;
        special = (o inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU} && y == 0) ||
                  (o inside {MD_DIV, MD_REM} && x == MIN32 && y == 32'hFFFF_FFFF);
        if (eo_c[d] != 0 && special) return 1;
        return 32 / unroll_c[d] + 1;
    endfunction

    // Issue one op to all three units at once and check result, latency, busy span, single done
    task automatic run_all(input md_op_e o, input logic [31:0] x, input logic [31:0] y,
                           input logic [31:0] e, input string tag);
        int lat [3];
        int busyc [3];
        int dcnt [3];
        logic [31:0] res [3];
        for (int d = 0; d < 3; d++) begin
            lat[d] = -1; busyc[d] = 0; dcnt[d] = 0; res[d] = '0;
        end
        op = o; a = x; b = y; st = 3'b111;
        @(posedge clk); #1;
        st = 3'b000;
        for (int k = 0; k <= 40; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            for (int d = 0; d < 3; d++) begin
                if (bz[d]) busyc[d]++;
                if (dn[d]) begin
                    dcnt[d]++;
                    if (lat[d] < 0) begin
                        lat[d] = k;
                        res[d] = rs[d];
                    end
                end
            end
            if (k == 2) begin
                a = $urandom; b = $urandom; op = md_op_e'($urandom_range(0, 7));
            end
        end
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("%s.result.dut%0d", tag, d), res[d], e);
            chk($sformatf("%s.latency.dut%0d", tag, d), 32'(lat[d]), 32'(exp_lat(d, o, x, y)));
            chk($sformatf("%s.busycycles.dut%0d", tag, d), 32'(busyc[d]), 32'(exp_lat(d, o, x, y)));
            chk($sformatf("%s.donepulses.dut%0d", tag, d), 32'(dcnt[d]), 32'd1);
        end
        last_exp = e;
    endtask

    initial begin
        int lat1, lat2, extra;
        logic [31:0] r1, r2;
        md_op_e ro;
        logic [31:0] rx, ry;

        reset = 1'b0; st = '0; flush = 1'b0; op = MD_MUL; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("reset.busy.dut%0d", d), 32'(bz[d]), 32'd0);
            chk($sformatf("reset.done.dut%0d", d), 32'(dn[d]), 32'd0);
            chk($sformatf("reset.result.dut%0d", d), rs[d], 32'd0);
        end
        reset = 1'b1;
        @(posedge clk); #1;

        tbl.push_back('{MD_MUL,    32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB});
        tbl.push_back('{MD_MULH,   MIN32,        MIN32,         32'h4000_0000});
        tbl.push_back('{MD_MULHU,  MIN32,        MIN32,         32'h4000_0000});
        tbl.push_back('{MD_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF});
        tbl.push_back('{MD_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE});
        tbl.push_back('{MD_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000});
        tbl.push_back('{MD_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001});
        tbl.push_back('{MD_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD});
        tbl.push_back('{MD_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF});
        tbl.push_back('{MD_DIV,    32'd7,        32'hFFFF_FFFE, 32'hFFFF_FFFD});
        tbl.push_back('{MD_REM,    32'd7,        32'hFFFF_FFFE, 32'h0000_0001});
        tbl.push_back('{MD_DIVU,   32'd100,      32'd7,         32'd14});
        tbl.push_back('{MD_REMU,   32'd100,      32'd7,         32'd2});
        tbl.push_back('{MD_DIVU,   32'h1234,     32'd0,         32'hFFFF_FFFF});
        tbl.push_back('{MD_REM,    32'h1234,     32'd0,         32'h0000_1234});
        tbl.push_back('{MD_DIV,    32'hFFFF_FF00, 32'd0,        32'hFFFF_FFFF});
        tbl.push_back('{MD_REM,    32'hFFFF_FF00, 32'd0,        32'hFFFF_FF00});
        tbl.push_back('{MD_DIV,    MIN32,        32'hFFFF_FFFF, MIN32});
        tbl.push_back('{MD_REM,    MIN32,        32'hFFFF_FFFF, 32'h0000_0000});
        tbl.push_back('{MD_DIVU,   MIN32,        32'hFFFF_FFFF, 32'h0000_0000});
        tbl.push_back('{MD_REMU,   MIN32,        32'hFFFF_FFFF, MIN32});
        tbl.push_back('{MD_DIVU,   32'hFFFF_FFFF, 32'd1,        32'hFFFF_FFFF});

        for (int i = 0; i < tbl.size(); i++) begin
            run_all(tbl[i].o, tbl[i].x, tbl[i].y, tbl[i].e, $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 30; i++) begin
            ro = md_op_e'($urandom_range(0, 7));
            rx = $urandom;
            ry = $urandom;
            case ($urandom_range(0, 9))
                0: ry = 32'd0;
                1: begin rx = MIN32; ry = 32'hFFFF_FFFF; end
                2: ry = 32'($urandom_range(1, 15));
                default: ;
            endcase
            run_all(ro, rx, ry, model(ro, rx, ry), $sformatf("rnd%0d", i));
        end

        // flush on the 10th cycle of a MUL on dut0
        op = MD_MUL; a = 32'd5; b = 32'd6; st = 3'b001;
        @(posedge clk); #1;
        st = 3'b000;
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush.busy", 32'(bz[0]), 32'd0);
        chk("flush.done", 32'(dn[0]), 32'd0);
        chk("flush.result", rs[0], last_exp);
        extra = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (dn[0] || bz[0]) extra++;
        end
        chk("flush.quiet", 32'(extra), 32'd0);

        // flush together with start in IDLE: nothing accepted
        op = MD_DIVU; a = 32'd9; b = 32'd3; st = 3'b001; flush = 1'b1;
        @(posedge clk); #1;
        st = 3'b000; flush = 1'b0;
        chk("flushidle.busy", 32'(bz[0]), 32'd0);
        extra = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (dn[0]) extra++;
        end
        chk("flushidle.nodone", 32'(extra), 32'd0);
        chk("flushidle.result", rs[0], last_exp);

        // back-to-back: start in the done cycle is accepted; start while busy is ignored
        op = MD_DIVU; a = 32'd100; b = 32'd7; st = 3'b001;
        @(posedge clk); #1;
        st = 3'b000;
        lat1 = -1; r1 = '0;
        for (int k = 0; k <= 60 && lat1 < 0; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            if (dn[0]) begin
                lat1 = k; r1 = rs[0];
                chk("b2b.busy_in_done", 32'(bz[0]), 32'd0);
                op = MD_REMU; st = 3'b001;
            end
        end
        chk("b2b.first.latency", 32'(lat1), 32'd33);
        chk("b2b.first.result", r1, 32'd14);
        @(posedge clk); #1;
        st = 3'b000;
        lat2 = -1; r2 = '0; extra = 0;
        for (int k = 0; k <= 45; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            if (k == 3) begin
                st = 3'b001; op = MD_MUL; a = 32'd3; b = 32'd3;
            end
            if (k == 4) st = 3'b000;
            if (dn[0]) begin
                if (lat2 < 0) begin
                    lat2 = k; r2 = rs[0];
                end else begin
                    extra++;
                end
            end
        end
        chk("b2b.second.latency", 32'(lat2), 32'd33);
        chk("b2b.second.result", r2, 32'd2);
        chk("b2b.no_queued", 32'(extra), 32'd0);

        // reset in the middle of a DIV; start held high during reset is ignored
        op = MD_DIV; a = 32'hFFFF_FFF9; b = 32'd2; st = 3'b001;
        @(posedge clk); #1;
        st = 3'b000;
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b0; st = 3'b111;
        @(posedge clk); #1;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("midreset.busy.dut%0d", d), 32'(bz[d]), 32'd0);
            chk($sformatf("midreset.done.dut%0d", d), 32'(dn[d]), 32'd0);
            chk($sformatf("midreset.result.dut%0d", d), rs[d], 32'd0);
        end
        @(posedge clk); #1;
        chk("midreset.hold.busy", 32'(bz[0]), 32'd0);
        st = 3'b000; reset = 1'b1;
        extra = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (dn[0] || bz[0]) extra++;
        end
        chk("midreset.quiet", 32'(extra), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
